agu_issue_arbiter: RTL and testbench

AGU_ISSUE_ARBITER -- requirements
Module: agu_issue_arbiter

---
 rtl/agu_issue_arbiter_pkg.sv | 14 +
 rtl/agu_issue_arbiter_if.sv | 38 +++
 rtl/agu_issue_arbiter_rob_age_cmp.sv | 15 +
 rtl/agu_issue_arbiter.sv | 60 ++++++
 tb/tb_agu_issue_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agu_issue_arbiter_pkg.sv
// agu_issue_arbiter_pkg: memory-system request field widths and packed request type
package agu_issue_arbiter_pkg;
  localparam int ROB_W  = 6;
  localparam int OP_W   = 4;
  localparam int DEST_W = 6;
  localparam int XLEN   = 32;
  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [OP_W-1:0]   op;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   addr;
    logic [DEST_W-1:0] dest;
  } req_t;
endpackage

// File: rtl/agu_issue_arbiter_if.sv
// agu_issue_arbiter_if: two requester ports plus the AGU-side issue port
interface agu_issue_arbiter_if import agu_issue_arbiter_pkg::*; ();
  logic              req0_vld_i;
  logic [ROB_W-1:0]  req0_rob_i;
  logic [OP_W-1:0]   req0_op_i;
  logic [XLEN-1:0]   req0_data_i;
  logic [XLEN-1:0]   req0_addr_i;
  logic [DEST_W-1:0] req0_dest_i;
  logic              req0_ack_o;
  logic              req1_vld_i;
  logic [ROB_W-1:0]  req1_rob_i;
  logic [OP_W-1:0]   req1_op_i;
  logic [XLEN-1:0]   req1_data_i;
  logic [XLEN-1:0]   req1_addr_i;
  logic [DEST_W-1:0] req1_dest_i;
  logic              req1_ack_o;
  logic              agu_busy_i;
  logic              agu_vld_o;
  logic [ROB_W-1:0]  agu_rob_o;
  logic [OP_W-1:0]   agu_op_o;
  logic [XLEN-1:0]   agu_data_o;
  logic [XLEN-1:0]   agu_addr_o;
  logic [DEST_W-1:0] agu_dest_o;
  modport slave (
    input  req0_vld_i, req0_rob_i, req0_op_i, req0_data_i, req0_addr_i, req0_dest_i,
    input  req1_vld_i, req1_rob_i, req1_op_i, req1_data_i, req1_addr_i, req1_dest_i,
    input  agu_busy_i,
    output req0_ack_o, req1_ack_o,
    output agu_vld_o, agu_rob_o, agu_op_o, agu_data_o, agu_addr_o, agu_dest_o
  );
  modport master (
    output req0_vld_i, req0_rob_i, req0_op_i, req0_data_i, req0_addr_i, req0_dest_i,
    output req1_vld_i, req1_rob_i, req1_op_i, req1_data_i, req1_addr_i, req1_dest_i,
    output agu_busy_i,
    input  req0_ack_o, req1_ack_o,
    input  agu_vld_o, agu_rob_o, agu_op_o, agu_data_o, agu_addr_o, agu_dest_o
  );
endinterface

// File: rtl/agu_issue_arbiter_rob_age_cmp.sv
// rob_age_cmp: a_older is high when rob_a is older than or the same age as rob_b relative to head
module rob_age_cmp import agu_issue_arbiter_pkg::*; (
  input  logic [ROB_W-1:0] head,
  input  logic [ROB_W-1:0] rob_a,
  input  logic [ROB_W-1:0] rob_b,
  output logic             a_older
);
  logic [ROB_W-1:0] age_a, age_b;
  // Ages wrap modulo the ROB size, so distance from head orders entries correctly
  always_comb begin
    age_a   = rob_a - head;
    age_b   = rob_b - head;
    a_older = age_a <= age_b;
  end
endmodule

// File: rtl/agu_issue_arbiter.sv
// agu_issue_arbiter: age-ordered two-way arbiter feeding a single AGU issue register
module agu_issue_arbiter import agu_issue_arbiter_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_i,
  input  logic              flush_i,
  input  logic [ROB_W-1:0]  rob_head_i,
  agu_issue_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  conflict_cnt_o
);
  logic             vld_q, vld_d;
  req_t             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req0, req1;
  logic             r0_older, ok, ack0, ack1, both;
  assign req0 = '{rob: bus.req0_rob_i, op: bus.req0_op_i, data: bus.req0_data_i,
                  addr: bus.req0_addr_i, dest: bus.req0_dest_i};
  assign req1 = '{rob: bus.req1_rob_i, op: bus.req1_op_i, data: bus.req1_data_i,
                  addr: bus.req1_addr_i, dest: bus.req1_dest_i};
  rob_age_cmp u_age (
    .head    (rob_head_i),
    .rob_a   (bus.req0_rob_i),
    .rob_b   (bus.req1_rob_i),
    .a_older (r0_older)
  );
  // Grant when the register is free or draining; reset and flush suppress all grants
  always_comb begin
    ok    = ~cpu_reset_i & ~flush_i & (~vld_q | ~bus.agu_busy_i);
    ack0  = ok & bus.req0_vld_i & (~bus.req1_vld_i | r0_older);
    ack1  = ok & bus.req1_vld_i & (~bus.req0_vld_i | ~r0_older);
    out_d = ack1 ? req1 : ack0 ? req0 : out_q;
    vld_d = flush_i ? 1'b0 : (ack0 | ack1) ? 1'b1 : vld_q & bus.agu_busy_i;
    both  = bus.req0_vld_i & bus.req1_vld_i;
    cnt_d = (both & ~flush_i & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // Control state: valid flag and saturating conflict counter
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end
  // Datapath fields carry no reset; they only matter while valid
  always_ff @(posedge cpu_clock_i) begin
    out_q <= out_d;
  end
  assign bus.req0_ack_o = ack0;
  assign bus.req1_ack_o = ack1;
  assign bus.agu_vld_o  = vld_q;
  assign bus.agu_rob_o  = out_q.rob;
  assign bus.agu_op_o   = out_q.op;
  assign bus.agu_data_o = out_q.data;
  assign bus.agu_addr_o = out_q.addr;
  assign bus.agu_dest_o = out_q.dest;
  assign conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_agu_issue_arbiter.sv
// tb_agu_issue_arbiter: scoreboard-driven checks of arbitration, backpressure, flush, saturation, reset
module tb_agu_issue_arbiter;
  import agu_issue_arbiter_pkg::*;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  head;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  req_t        sb[$];
  req_t        exp_r, a, b;

  always #5 clk = ~clk;

  agu_issue_arbiter_if bus ();
  agu_issue_arbiter_if bus4 ();

  assign bus4.req0_vld_i  = bus.req0_vld_i;
  assign bus4.req0_rob_i  = bus.req0_rob_i;
  assign bus4.req0_op_i   = bus.req0_op_i;
  assign bus4.req0_data_i = bus.req0_data_i;
  assign bus4.req0_addr_i = bus.req0_addr_i;
  assign bus4.req0_dest_i = bus.req0_dest_i;
  assign bus4.req1_vld_i  = bus.req1_vld_i;
  assign bus4.req1_rob_i  = bus.req1_rob_i;
  assign bus4.req1_op_i   = bus.req1_op_i;
  assign bus4.req1_data_i = bus.req1_data_i;
  assign bus4.req1_addr_i = bus.req1_addr_i;
  assign bus4.req1_dest_i = bus.req1_dest_i;
  assign bus4.agu_busy_i  = bus.agu_busy_i;

  agu_issue_arbiter dut (
    .cpu_clock_i    (clk),
    .cpu_reset_i    (rst),
    .flush_i        (flush),
    .rob_head_i     (head),
    .bus            (bus),
    .conflict_cnt_o (cnt)
  );

  agu_issue_arbiter #(.CNT_W(4)) dut4 (
    .cpu_clock_i    (clk),
    .cpu_reset_i    (rst),
    .flush_i        (flush),
    .rob_head_i     (head),
    .bus            (bus4),
    .conflict_cnt_o (cnt4)
  );

  function automatic req_t obs();
    return '{rob: bus.agu_rob_o, op: bus.agu_op_o, data: bus.agu_data_o,
             addr: bus.agu_addr_o, dest: bus.agu_dest_o};
  endfunction

  function automatic req_t mk(input logic [5:0] rob, input logic [31:0] addr);
    req_t r;
    r.rob  = rob;
    r.op   = 4'($urandom);
    r.data = $urandom;
    r.addr = addr;
    r.dest = 6'($urandom);
    return r;
  endfunction

  task automatic drive(input int n, input logic v, input req_t r);
    if (n == 0) begin
      bus.req0_vld_i = v; bus.req0_rob_i = r.rob; bus.req0_op_i = r.op;
      bus.req0_data_i = r.data; bus.req0_addr_i = r.addr; bus.req0_dest_i = r.dest;
    end else begin
      bus.req1_vld_i = v; bus.req1_rob_i = r.rob; bus.req1_op_i = r.op;
      bus.req1_data_i = r.data; bus.req1_addr_i = r.addr; bus.req1_dest_i = r.dest;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; head = 6'd0; bus.agu_busy_i = 1'b0;
    drive(0, 1'b1, mk(6'd1, 32'h10));
    drive(1, 1'b1, mk(6'd2, 32'h20));
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b0) $display("FAIL reset_ack0: got %b want 0", bus.req0_ack_o); else pass_cnt++;
    chk_cnt++; if (bus.req1_ack_o !== 1'b0) $display("FAIL reset_ack1: got %b want 0", bus.req1_ack_o); else pass_cnt++;
    step(); step();
    sample();
    chk_cnt++; if (bus.agu_vld_o !== 1'b0) $display("FAIL reset_vld: got %b want 0", bus.agu_vld_o); else pass_cnt++;
    chk_cnt++; if (cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else pass_cnt++;
    chk_cnt++; if (cnt4 !== 4'd0) $display("FAIL reset_cnt4: got %0d want 0", cnt4); else pass_cnt++;
    rst = 1'b0;
    drive(0, 1'b0, a);
    drive(1, 1'b0, a);
    step();
  endtask

  task automatic test_single();
    head = 6'd0;
    a = mk(6'd5, 32'h1000);
    drive(0, 1'b1, a);
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b1) $display("FAIL single_ack0: got %b want 1", bus.req0_ack_o); else pass_cnt++;
    chk_cnt++; if (bus.req1_ack_o !== 1'b0) $display("FAIL single_ack1: got %b want 0", bus.req1_ack_o); else pass_cnt++;
    sb.push_back(a);
    step();
    drive(0, 1'b0, a);
    sample();
    chk_cnt++; if (bus.agu_vld_o !== 1'b1) $display("FAIL single_vld: got %b want 1", bus.agu_vld_o); else pass_cnt++;
    chk_cnt++; if (bus.agu_addr_o !== 32'h1000) $display("FAIL single_addr: got %h want 00001000", bus.agu_addr_o); else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL single_sb: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r) $display("FAIL single_fields: got %h want %h", obs(), exp_r); else pass_cnt++;
    end
    step();
    sample();
    chk_cnt++; if (bus.agu_vld_o !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.agu_vld_o); else pass_cnt++;
    step();
  endtask

  task automatic test_age_wrap();
    head = 6'd60;
    a = mk(6'd2, 32'h2000);
    b = mk(6'd62, 32'h3000);
    drive(0, 1'b1, a);
    drive(1, 1'b1, b);
    sample();
    chk_cnt++; if (bus.req1_ack_o !== 1'b1) $display("FAIL age_ack1: got %b want 1", bus.req1_ack_o); else pass_cnt++;
    chk_cnt++; if (bus.req0_ack_o !== 1'b0) $display("FAIL age_ack0_first: got %b want 0", bus.req0_ack_o); else pass_cnt++;
    sb.push_back(b);
    step();
    drive(1, 1'b0, b);
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b1) $display("FAIL age_ack0_second: got %b want 1", bus.req0_ack_o); else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL age_sb1: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r || bus.agu_vld_o !== 1'b1) $display("FAIL age_out1: got %h vld %b want %h vld 1", obs(), bus.agu_vld_o, exp_r); else pass_cnt++;
    end
    sb.push_back(a);
    step();
    drive(0, 1'b0, a);
    sample();
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL age_sb2: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r || bus.agu_vld_o !== 1'b1) $display("FAIL age_out2: got %h vld %b want %h vld 1", obs(), bus.agu_vld_o, exp_r); else pass_cnt++;
    end
    chk_cnt++; if (cnt !== 16'd1) $display("FAIL age_cnt: got %0d want 1", cnt); else pass_cnt++;
    chk_cnt++; if (cnt4 !== 4'd1) $display("FAIL age_cnt4: got %0d want 1", cnt4); else pass_cnt++;
    step(); step();
  endtask

  task automatic test_backpressure();
    head = 6'd0;
    a = mk(6'd10, 32'h4000);
    b = mk(6'd11, 32'h5000);
    bus.agu_busy_i = 1'b0;
    drive(0, 1'b1, a);
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b1) $display("FAIL bp_load_ack0: got %b want 1", bus.req0_ack_o); else pass_cnt++;
    sb.push_back(a);
    step();
    bus.agu_busy_i = 1'b1;
    drive(0, 1'b1, b);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk_cnt++; if (bus.req0_ack_o !== 1'b0) $display("FAIL bp_hold_ack0 cyc%0d: got %b want 0", i, bus.req0_ack_o); else pass_cnt++;
      chk_cnt++; if (bus.agu_vld_o !== 1'b1 || obs() !== sb[0]) $display("FAIL bp_hold_out cyc%0d: got %h vld %b want %h vld 1", i, obs(), bus.agu_vld_o, sb[0]); else pass_cnt++;
      step();
    end
    bus.agu_busy_i = 1'b0;
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b1) $display("FAIL bp_release_ack0: got %b want 1", bus.req0_ack_o); else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL bp_sb1: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r) $display("FAIL bp_out1: got %h want %h", obs(), exp_r); else pass_cnt++;
    end
    sb.push_back(b);
    step();
    drive(0, 1'b0, b);
    sample();
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL bp_sb2: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r || bus.agu_vld_o !== 1'b1) $display("FAIL bp_out2: got %h vld %b want %h vld 1", obs(), bus.agu_vld_o, exp_r); else pass_cnt++;
    end
    step(); step();
  endtask

  task automatic test_flush();
    a = mk(6'd20, 32'h6000);
    b = mk(6'd21, 32'h7000);
    bus.agu_busy_i = 1'b0;
    drive(0, 1'b1, a);
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b1) $display("FAIL flush_load_ack0: got %b want 1", bus.req0_ack_o); else pass_cnt++;
    sb.push_back(a);
    step();
    drive(0, 1'b0, a);
    bus.agu_busy_i = 1'b1;
    flush = 1'b1;
    drive(1, 1'b1, b);
    sample();
    chk_cnt++; if (bus.req1_ack_o !== 1'b0) $display("FAIL flush_ack1: got %b want 0", bus.req1_ack_o); else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL flush_sb1: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r || bus.agu_vld_o !== 1'b1) $display("FAIL flush_out1: got %h vld %b want %h vld 1", obs(), bus.agu_vld_o, exp_r); else pass_cnt++;
    end
    step();
    flush = 1'b0;
    sample();
    chk_cnt++; if (bus.agu_vld_o !== 1'b0) $display("FAIL flush_vld: got %b want 0", bus.agu_vld_o); else pass_cnt++;
    chk_cnt++; if (bus.req1_ack_o !== 1'b1) $display("FAIL flush_after_ack1: got %b want 1", bus.req1_ack_o); else pass_cnt++;
    sb.push_back(b);
    step();
    drive(1, 1'b0, b);
    sample();
    chk_cnt++;
    if (sb.size() == 0) $display("FAIL flush_sb2: got empty queue want entry");
    else begin
      exp_r = sb.pop_front();
      if (obs() !== exp_r || bus.agu_vld_o !== 1'b1) $display("FAIL flush_out2: got %h vld %b want %h vld 1", obs(), bus.agu_vld_o, exp_r); else pass_cnt++;
    end
    bus.agu_busy_i = 1'b0;
    step(); step();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    head = 6'd0;
    bus.agu_busy_i = 1'b1;
    drive(0, 1'b1, mk(6'd30, 32'h8000));
    drive(1, 1'b1, mk(6'd31, 32'h9000));
    for (int i = 1; i <= 20; i++) begin
      step();
      sample();
      if (i == 15) begin
        chk_cnt++; if (cnt4 !== 4'd15) $display("FAIL sat_cnt4_at15: got %0d want 15", cnt4); else pass_cnt++;
      end
    end
    chk_cnt++; if (cnt4 !== 4'd15) $display("FAIL sat_cnt4_end: got %0d want 15", cnt4); else pass_cnt++;
    chk_cnt++; if (cnt !== 16'd20) $display("FAIL sat_cnt16_end: got %0d want 20", cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    sample();
    chk_cnt++; if (bus.agu_vld_o !== 1'b1) $display("FAIL rstmid_full: got %b want 1", bus.agu_vld_o); else pass_cnt++;
    step();
    rst = 1'b1;
    bus.agu_busy_i = 1'b0;
    sample();
    chk_cnt++; if (bus.req0_ack_o !== 1'b0) $display("FAIL rstmid_ack0: got %b want 0", bus.req0_ack_o); else pass_cnt++;
    chk_cnt++; if (bus.req1_ack_o !== 1'b0) $display("FAIL rstmid_ack1: got %b want 0", bus.req1_ack_o); else pass_cnt++;
    step();
    sample();
    chk_cnt++; if (bus.agu_vld_o !== 1'b0) $display("FAIL rstmid_vld: got %b want 0", bus.agu_vld_o); else pass_cnt++;
    chk_cnt++; if (cnt !== 16'd0) $display("FAIL rstmid_cnt: got %0d want 0", cnt); else pass_cnt++;
    chk_cnt++; if (cnt4 !== 4'd0) $display("FAIL rstmid_cnt4: got %0d want 0", cnt4); else pass_cnt++;
    rst = 1'b0;
    drive(0, 1'b0, a);
    drive(1, 1'b0, a);
    step();
  endtask

  initial begin
    a = '0;
    b = '0;
    test_reset();
    test_single();
    test_age_wrap();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid();
    chk_cnt++; if (sb.size() != 0) $display("FAIL sb_empty: got %0d entries want 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
